// File: rtl/mem_wb_stage_if.sv
// MEM -> WB handshake bundle: per-lane valids, {line2,line1} data bus,
// exception flush and the allowin back-pressure returned to MEM.
interface mem_wb_stage_if #(
    parameter int L = 70
);
    logic           line1_pre_to_now_valid_i;
    logic           line2_pre_to_now_valid_i;
    logic           now_allowin_o;
    logic           excep_flush_i;
    logic [2*L-1:0] pre_to_ibus;

    modport master (
        output line1_pre_to_now_valid_i, line2_pre_to_now_valid_i,
        output excep_flush_i, pre_to_ibus,
        input  now_allowin_o
    );

    modport slave (
        input  line1_pre_to_now_valid_i, line2_pre_to_now_valid_i,
        input  excep_flush_i, pre_to_ibus,
        output now_allowin_o
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Dual-lane MEM/WB register, register-file write ports, WB forwarding and retire count.
// Define WB_TRACE_SERIAL_EN to commit one lane per cycle through port 1 only.

module mem_wb_lane #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load_i,
    input  logic                            vld_i,
    input  logic [PC_W+1+REG_AW+DATA_W-1:0] bus_i,
    output logic [PC_W-1:0]                 pc_o,
    output logic [REG_AW-1:0]               waddr_o,
    output logic [DATA_W-1:0]               wdata_o,
    output logic                            wr_ok_o,
    output logic [REG_AW+DATA_W:0]          fwd_o
);
    logic [PC_W-1:0]   pc_q;
    logic              we_q;
    logic [REG_AW-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (load_i) begin
            {pc_q, we_q, waddr_q, wdata_q} <= bus_i;
        end
    end

    // Data outputs read zero while the lane holds no bundle.
    assign pc_o    = vld_i ? pc_q    : '0;
    assign waddr_o = vld_i ? waddr_q : '0;
    assign wdata_o = vld_i ? wdata_q : '0;
    assign wr_ok_o = vld_i & we_q & (waddr_q != '0);
    assign fwd_o   = {wr_ok_o, waddr_o, wdata_o};
endmodule

module mem_wb_stage #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mem_wb_stage_if.slave                 mem_if,
    output logic                          rf_we1_o,
    output logic                          rf_we2_o,
    output logic [REG_AW-1:0]             rf_waddr1_o,
    output logic [REG_AW-1:0]             rf_waddr2_o,
    output logic [DATA_W-1:0]             rf_wdata1_o,
    output logic [DATA_W-1:0]             rf_wdata2_o,
    output logic [2*(1+REG_AW+DATA_W)-1:0] forward_obus,
    output logic [CNT_W-1:0]              instret_o,
    output logic [PC_W-1:0]               debug1_pc_o,
    output logic [PC_W-1:0]               debug2_pc_o,
    output logic [3:0]                    debug1_we_o,
    output logic [3:0]                    debug2_we_o,
    output logic [REG_AW-1:0]             debug1_wnum_o,
    output logic [REG_AW-1:0]             debug2_wnum_o,
    output logic [DATA_W-1:0]             debug1_wdata_o,
    output logic [DATA_W-1:0]             debug2_wdata_o
);
    localparam int L  = PC_W + 1 + REG_AW + DATA_W;
    localparam int FW = 1 + REG_AW + DATA_W;

    typedef enum logic {FIRST = 1'b0, SECOND = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              vld_q, vld_d;
    logic [1:0]              in_vld;
    logic                    flush, ready_go, allowin, drop2, retire;
    logic [CNT_W-1:0]        instret_q, retire_cnt;

    logic [1:0][PC_W-1:0]    lane_pc;
    logic [1:0][REG_AW-1:0]  lane_waddr;
    logic [1:0][DATA_W-1:0]  lane_wdata;
    logic [1:0]              lane_wr_ok;

    assign in_vld = {mem_if.line2_pre_to_now_valid_i, mem_if.line1_pre_to_now_valid_i};
    assign flush  = mem_if.excep_flush_i;
    assign mem_if.now_allowin_o = allowin;

    for (genvar k = 0; k < 2; k++) begin : g_lane
        mem_wb_lane #(.PC_W(PC_W), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (allowin & ~flush & in_vld[k]),
            .vld_i   (vld_q[k]),
            .bus_i   (mem_if.pre_to_ibus[k*L +: L]),
            .pc_o    (lane_pc[k]),
            .waddr_o (lane_waddr[k]),
            .wdata_o (lane_wdata[k]),
            .wr_ok_o (lane_wr_ok[k]),
            .fwd_o   (forward_obus[k*FW +: FW])
        );
    end

    always_comb begin
        state_d  = FIRST;
        ready_go = 1'b1;
`ifdef WB_TRACE_SERIAL_EN
        // A dual bundle holds the stage for two cycles: line1 then line2.
        case (state_q)
            FIRST: if (&vld_q) begin
                ready_go = 1'b0;
                state_d  = SECOND;
            end
            SECOND: begin
                ready_go = 1'b1;
                state_d  = FIRST;
            end
            default: state_d = FIRST;
        endcase
`endif
        allowin = ~|vld_q | ready_go;
        vld_d   = allowin ? in_vld : vld_q;
        if (flush) begin
            vld_d   = 2'b00;
            state_d = FIRST;
        end
    end

    // A flush during the second serialized cycle discards line2 uncommitted.
    assign drop2      = (state_q == SECOND) & flush;
    assign retire     = ready_go & (|vld_q) & ~drop2;
    assign retire_cnt = CNT_W'(vld_q[0]) + CNT_W'(vld_q[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= 2'b00;
            state_q   <= FIRST;
            instret_q <= '0;
        end else begin
            vld_q   <= vld_d;
            state_q <= state_d;
            if (retire) instret_q <= instret_q + retire_cnt;
        end
    end

    assign instret_o = instret_q;

`ifdef WB_TRACE_SERIAL_EN
    logic sel, act;

    // Port 1 carries line2 in the second cycle, or a lone line2 bundle.
    assign sel = (state_q == SECOND) | ~vld_q[0];
    assign act = (|vld_q) & ~drop2;

    always_comb begin
        rf_we1_o       = 1'b0;
        rf_waddr1_o    = '0;
        rf_wdata1_o    = '0;
        debug1_pc_o    = '0;
        debug1_wnum_o  = '0;
        debug1_wdata_o = '0;
        if (act) begin
            rf_we1_o       = lane_wr_ok[sel];
            rf_waddr1_o    = lane_waddr[sel];
            rf_wdata1_o    = lane_wdata[sel];
            debug1_pc_o    = lane_pc[sel];
            debug1_wnum_o  = lane_waddr[sel];
            debug1_wdata_o = lane_wdata[sel];
        end
    end

    assign rf_we2_o       = 1'b0;
    assign rf_waddr2_o    = '0;
    assign rf_wdata2_o    = '0;
    assign debug2_pc_o    = '0;
    assign debug2_wnum_o  = '0;
    assign debug2_wdata_o = '0;
`else
    logic act1, act2, collide;

    assign act1    = vld_q[0] & (state_q == FIRST);
    assign act2    = vld_q[1] & (state_q == FIRST);
    // Same-register double write: the younger lane (line2) takes it.
    assign collide = lane_wr_ok[0] & lane_wr_ok[1] & (lane_waddr[0] == lane_waddr[1]);

    always_comb begin
        rf_we1_o       = act1 & lane_wr_ok[0] & ~collide;
        rf_we2_o       = act2 & lane_wr_ok[1];
        rf_waddr1_o    = act1 ? lane_waddr[0] : '0;
        rf_waddr2_o    = act2 ? lane_waddr[1] : '0;
        rf_wdata1_o    = act1 ? lane_wdata[0] : '0;
        rf_wdata2_o    = act2 ? lane_wdata[1] : '0;
        debug1_pc_o    = act1 ? lane_pc[0] : '0;
        debug2_pc_o    = act2 ? lane_pc[1] : '0;
        debug1_wnum_o  = rf_waddr1_o;
        debug2_wnum_o  = rf_waddr2_o;
        debug1_wdata_o = rf_wdata1_o;
        debug2_wdata_o = rf_wdata2_o;
    end
`endif

    assign debug1_we_o = {4{rf_we1_o}};
    assign debug2_we_o = {4{rf_we2_o}};
endmodule
